// File: rtl/jk_bank_sequencer.sv
// ---------------------------------------------------------------------------
// jk_bank_sequencer
//   Command-driven controller for a bank of WIDTH JK flip-flops. The block
//   accepts one command per valid/ready handshake (LOAD, COUNT_UP,
//   COUNT_DOWN, TOGGLE), computes the per-bit J/K drive each cycle, and
//   pulses done for one cycle when the command completes.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-high reset
//     cmd_valid  command present
//     cmd_ready  block can accept a command (high only in IDLE)
//     cmd_op     00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 TOGGLE
//     cmd_data   load value (LOAD) or toggle mask (TOGGLE)
//     cmd_steps  number of count steps (COUNT_UP / COUNT_DOWN)
//     abort      ends an in-progress COUNT without performing that step
//     q, q_n     JK bank true / complement outputs
//     busy       high whenever the sequencer is not IDLE
//     done       one-cycle completion pulse
// ---------------------------------------------------------------------------

// Bank of JK flip-flops with registered true and complement outputs.
module jk_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_n_r;
    logic [WIDTH-1:0] q_next_s;

    // JK characteristic equation: set, reset, toggle or hold per bit.
    always_comb begin
        q_next_s = (j & ~q_r) | (~k & q_r);
    end

    // Storage; the complement is its own register so q_n == ~q at every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r   <= {WIDTH{1'b0}};
            q_n_r <= {WIDTH{1'b1}};
        end else begin
            q_r   <= q_next_s;
            q_n_r <= ~q_next_s;
        end
    end

    assign q   = q_r;
    assign q_n = q_n_r;

endmodule

module jk_bank_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_n,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_TOGGLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  data_r;
    logic [STEP_W-1:0] count_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              accept_s;
    logic              step_s;
    logic [WIDTH-1:0]  toggle_s;
    logic [WIDTH-1:0]  j_s;
    logic [WIDTH-1:0]  k_s;
    logic              carry_s;

    assign accept_s = cmd_valid && (state_r == ST_IDLE);
    // A RUN cycle steps unless abort claims it; abort wins over the final step.
    assign step_s   = (state_r == ST_RUN) && !abort;

    // Counter toggle pattern: bit i toggles when all lower bits are 1 (up)
    // or all lower bits are 0 (down, via q_n); bit 0 always toggles.
    always_comb begin
        toggle_s = {WIDTH{1'b0}};
        carry_s  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            toggle_s[i] = carry_s;
            if (op_r == OP_DOWN) begin
                carry_s = carry_s & q_n[i];
            end else begin
                carry_s = carry_s & q[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_LOAD:   next_state_s = ST_LOAD;
                        OP_TOGGLE: next_state_s = ST_TOGGLE;
                        OP_UP,
                        OP_DOWN: begin
                            if (cmd_steps != {STEP_W{1'b0}}) begin
                                next_state_s = ST_RUN;
                            end else begin
                                next_state_s = ST_DONE;
                            end
                        end
                        default:   next_state_s = ST_IDLE;
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD:   next_state_s = ST_DONE;
            ST_TOGGLE: next_state_s = ST_DONE;
            ST_RUN: begin
                if (abort) begin
                    next_state_s = ST_DONE;
                end else if (count_r == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // J/K drive; everything outside LOAD, TOGGLE and a live RUN step holds q.
    always_comb begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
        case (state_r)
            ST_LOAD: begin
                j_s = data_r;
                k_s = ~data_r;
            end
            ST_TOGGLE: begin
                j_s = data_r;
                k_s = data_r;
            end
            ST_RUN: begin
                if (step_s) begin
                    j_s = toggle_s;
                    k_s = toggle_s;
                end else begin
                    j_s = {WIDTH{1'b0}};
                    k_s = {WIDTH{1'b0}};
                end
            end
            default: begin
                j_s = {WIDTH{1'b0}};
                k_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // State register and command capture at the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= 2'b00;
            data_r  <= {WIDTH{1'b0}};
            count_r <= {STEP_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                op_r    <= cmd_op;
                data_r  <= cmd_data;
                count_r <= cmd_steps;
            end else if (step_s) begin
                count_r <= count_r - {{(STEP_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Status outputs registered from the next state so they track state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_IDLE);
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

    jk_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .j     (j_s),
        .k     (k_s),
        .q     (q),
        .q_n   (q_n)
    );

endmodule
